// File: rtl/beta_pipe_cu.sv
// rtl/beta_pipe_cu.sv - registered Beta decode/control stage with IRQ traps, annulment and load-use stalls
module beta_pipe_cu #(
  parameter int NUM_IRQ     = 4,
  parameter int ANNUL_SLOTS = 1,
  parameter int LU_BUBBLES  = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [31:0]        instruction,
  input  logic               in_super,
  input  logic               z,
  input  logic [NUM_IRQ-1:0] irq,
  output logic [NUM_IRQ-1:0] irq_ack,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               annul,
  output logic [5:0]         ALUFN,
  output logic               ASEL,
  output logic               BSEL,
  output logic               MOE,
  output logic               MWR,
  output logic [2:0]         PCSEL,
  output logic               RA2SEL,
  output logic               WASEL,
  output logic [1:0]         WDSEL,
  output logic               WERF
);

  localparam logic [1:0] S_RUN   = 2'd0;
  localparam logic [1:0] S_ANNUL = 2'd1;
  localparam logic [1:0] S_STALL = 2'd2;
  localparam logic [2:0] ANNUL_LAST  = 3'(ANNUL_SLOTS - 1);
  localparam logic [1:0] BUBBLE_LAST = 2'(LU_BUBBLES - 1);

  logic [1:0]         state;
  logic [2:0]         annul_cnt;
  logic [1:0]         bubble_cnt;
  logic [NUM_IRQ-1:0] pend;
  logic [4:0]         rc_q;

  logic [5:0] op;
  logic [4:0] rc, ra, rb;
  logic       is_op, is_st, load, hazard, accept, trap;
  logic [NUM_IRQ-1:0] ack_sel, ack_now;

  logic [5:0] d_alufn;
  logic       d_asel, d_bsel, d_moe, d_mwr, d_ra2sel, d_wasel, d_werf, d_redirect;
  logic [2:0] d_pcsel;
  logic [1:0] d_wdsel;

  assign op = instruction[31:26];
  assign rc = instruction[25:21];
  assign ra = instruction[20:16];
  assign rb = instruction[15:11];

  assign load  = !out_valid || out_ready;
  assign is_op = (op[5:4] == 2'b10);
  assign is_st = (op == 6'b011001);
  assign annul = (state == S_ANNUL);

  // MOE is only ever set on a valid issued load, so bubbles clear the hazard by themselves
  assign hazard = (LU_BUBBLES != 0) && MOE && (rc_q != 5'd31) &&
                  ((ra == rc_q) || (is_op && (rb == rc_q)) || (is_st && (rc == rc_q)));

  always_comb begin
    in_ready = 1'b0;
    if (!reset) begin
      case (state)
        S_RUN:   in_ready = load && !hazard;
        S_ANNUL: in_ready = 1'b1;
        default: in_ready = 1'b0;
      endcase
    end
  end

  assign accept = in_valid && in_ready;
  assign trap   = (state == S_RUN) && (pend != '0) && !in_super;

  always_comb begin
    ack_sel = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (pend[i]) begin
        ack_sel    = '0;
        ack_sel[i] = 1'b1;
      end
    end
  end

  assign ack_now = (accept && trap) ? ack_sel : '0;

  always_comb begin
    d_alufn    = '0;
    d_asel     = 1'b0;
    d_bsel     = 1'b0;
    d_moe      = 1'b0;
    d_mwr      = 1'b0;
    d_pcsel    = 3'b000;
    d_ra2sel   = 1'b0;
    d_wasel    = 1'b0;
    d_wdsel    = 2'b00;
    d_werf     = 1'b0;
    d_redirect = 1'b0;
    if (trap) begin
      d_pcsel    = 3'b100;
      d_wasel    = 1'b1;
      d_werf     = 1'b1;
      d_redirect = 1'b1;
    end else begin
      casez (op)
        6'b1?????: begin
          d_alufn = {2'b10, op[3:0]};
          d_bsel  = op[4];
          d_wdsel = 2'b01;
          d_werf  = 1'b1;
        end
        6'b011000: begin
          d_alufn = 6'b100000;
          d_bsel  = 1'b1;
          d_moe   = 1'b1;
          d_wdsel = 2'b10;
          d_werf  = 1'b1;
        end
        6'b011001: begin
          d_alufn  = 6'b100000;
          d_bsel   = 1'b1;
          d_ra2sel = 1'b1;
          d_mwr    = 1'b1;
        end
        6'b011111: begin
          d_asel  = 1'b1;
          d_moe   = 1'b1;
          d_wdsel = 2'b10;
          d_werf  = 1'b1;
        end
        6'b011011: begin
          d_pcsel    = 3'b010;
          d_werf     = 1'b1;
          d_redirect = 1'b1;
        end
        6'b011100, 6'b011101: begin
          d_werf = 1'b1;
          // op[0] selects BNE, which branches on z==0
          if (op[0] ^ z) begin
            d_pcsel    = 3'b001;
            d_redirect = 1'b1;
          end
        end
        default: begin
          d_pcsel    = 3'b011;
          d_wasel    = 1'b1;
          d_werf     = 1'b1;
          d_redirect = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_RUN;
      annul_cnt  <= '0;
      bubble_cnt <= '0;
      pend       <= '0;
      irq_ack    <= '0;
      rc_q       <= '0;
      out_valid  <= 1'b0;
      ALUFN      <= '0;
      ASEL       <= 1'b0;
      BSEL       <= 1'b0;
      MOE        <= 1'b0;
      MWR        <= 1'b0;
      PCSEL      <= '0;
      RA2SEL     <= 1'b0;
      WASEL      <= 1'b0;
      WDSEL      <= '0;
      WERF       <= 1'b0;
    end else begin
      pend    <= (pend & ~ack_now) | irq;
      irq_ack <= ack_now;

      if (load) begin
        if (accept && (state == S_RUN)) begin
          out_valid <= 1'b1;
          ALUFN     <= d_alufn;
          ASEL      <= d_asel;
          BSEL      <= d_bsel;
          MOE       <= d_moe;
          MWR       <= d_mwr;
          PCSEL     <= d_pcsel;
          RA2SEL    <= d_ra2sel;
          WASEL     <= d_wasel;
          WDSEL     <= d_wdsel;
          WERF      <= d_werf;
          rc_q      <= rc;
        end else begin
          // bubble or discarded slot: zeroed controls
          out_valid <= 1'b0;
          ALUFN     <= '0;
          ASEL      <= 1'b0;
          BSEL      <= 1'b0;
          MOE       <= 1'b0;
          MWR       <= 1'b0;
          PCSEL     <= '0;
          RA2SEL    <= 1'b0;
          WASEL     <= 1'b0;
          WDSEL     <= '0;
          WERF      <= 1'b0;
          rc_q      <= '0;
        end
      end

      case (state)
        S_RUN: begin
          if (accept && d_redirect) begin
            state     <= S_ANNUL;
            annul_cnt <= '0;
          end else if (in_valid && hazard && load && (LU_BUBBLES > 1)) begin
            state      <= S_STALL;
            bubble_cnt <= 2'd1;
          end
        end
        S_ANNUL: begin
          if (accept) begin
            if (annul_cnt == ANNUL_LAST) state <= S_RUN;
            else annul_cnt <= annul_cnt + 3'd1;
          end
        end
        default: begin
          if (load) begin
            if (bubble_cnt == BUBBLE_LAST) state <= S_RUN;
            else bubble_cnt <= bubble_cnt + 2'd1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_beta_pipe_cu.sv
// tb/tb_beta_pipe_cu.sv - scoreboard bench for beta_pipe_cu
module tb_beta_pipe_cu;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_super = 1'b0;
  logic        z = 1'b0;
  logic        out_ready = 1'b1;
  logic [31:0] instruction = '0;
  logic [3:0]  irq = '0;
  logic        in_ready, out_valid, annul;
  logic [3:0]  irq_ack;
  logic [5:0]  ALUFN;
  logic        ASEL, BSEL, MOE, MWR, RA2SEL, WASEL, WERF;
  logic [2:0]  PCSEL;
  logic [1:0]  WDSEL;

  int tests = 0;
  int fails = 0;
  logic [17:0] sb[$];
  logic [17:0] exp_w;

  beta_pipe_cu #(.NUM_IRQ(4), .ANNUL_SLOTS(2), .LU_BUBBLES(1)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .instruction(instruction), .in_super(in_super), .z(z), .irq(irq),
    .irq_ack(irq_ack), .out_valid(out_valid), .out_ready(out_ready), .annul(annul),
    .ALUFN(ALUFN), .ASEL(ASEL), .BSEL(BSEL), .MOE(MOE), .MWR(MWR),
    .PCSEL(PCSEL), .RA2SEL(RA2SEL), .WASEL(WASEL), .WDSEL(WDSEL), .WERF(WERF)
  );

  always #5 clk = ~clk;

  wire [17:0] obs = {ALUFN, ASEL, BSEL, MOE, MWR, PCSEL, RA2SEL, WASEL, WDSEL, WERF};

  // expected control word, straight from the opcode table
  function automatic logic [17:0] model(input logic [5:0] op, input logic zz, input bit trp);
    logic [5:0] alufn;
    logic       asel, bsel, moe, mwr, ra2sel, wasel, werf;
    logic [2:0] pcsel;
    logic [1:0] wdsel;
    alufn = '0; asel = 0; bsel = 0; moe = 0; mwr = 0; ra2sel = 0; wasel = 0; werf = 0;
    pcsel = '0; wdsel = '0;
    if (trp) begin
      pcsel = 3'b100; wasel = 1; werf = 1;
    end else if (op[5:4] == 2'b10) begin
      alufn = {2'b10, op[3:0]}; wdsel = 2'b01; werf = 1;
    end else if (op[5:4] == 2'b11) begin
      alufn = {2'b10, op[3:0]}; bsel = 1; wdsel = 2'b01; werf = 1;
    end else begin
      case (op)
        6'b011000: begin alufn = 6'b100000; bsel = 1; moe = 1; wdsel = 2'b10; werf = 1; end
        6'b011001: begin alufn = 6'b100000; bsel = 1; ra2sel = 1; mwr = 1; end
        6'b011111: begin asel = 1; moe = 1; wdsel = 2'b10; werf = 1; end
        6'b011011: begin pcsel = 3'b010; werf = 1; end
        6'b011100: begin werf = 1; pcsel = zz ? 3'b001 : 3'b000; end
        6'b011101: begin werf = 1; pcsel = zz ? 3'b000 : 3'b001; end
        default:   begin pcsel = 3'b011; wasel = 1; werf = 1; end
      endcase
    end
    return {alufn, asel, bsel, moe, mwr, pcsel, ra2sel, wasel, wdsel, werf};
  endfunction

  function automatic logic [31:0] mk(input logic [5:0] op, input logic [4:0] rc, input logic [4:0] ra,
                                     input logic [4:0] rb);
    return {op, rc, ra, rb, 11'd0};
  endfunction

  always @(negedge clk) begin
    if (out_valid && out_ready) begin
      tests++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL sb_unexpected_word got=%h required=none", obs);
      end else begin
        exp_w = sb.pop_front();
        if (obs !== exp_w) begin
          fails++;
          $display("FAIL sb_word got=%h required=%h", obs, exp_w);
        end
      end
    end
  end

  task automatic present(input logic [31:0] ins, input logic zz, input logic sup, output int waited);
    waited = 0;
    instruction = ins; z = zz; in_super = sup; in_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk); #1;
        break;
      end
      @(posedge clk); #1;
      waited++;
      if (waited > 20) begin
        tests++; fails++;
        $display("FAIL accept_timeout ins=%h waited=%0d", ins, waited);
        break;
      end
    end
    in_valid = 1'b0; z = 1'b0; in_super = 1'b0;
  endtask

  task automatic send(input logic [31:0] ins, input logic zz, input logic sup, input bit trp,
                      output int waited);
    sb.push_back(model(ins[31:26], zz, trp));
    present(ins, zz, sup, waited);
  endtask

  task automatic discard2(input string tag);
    int w;
    for (int k = 0; k < 2; k++) begin
      present(mk(6'b100000, 5'd9, 5'd9, 5'd9), 1'b0, 1'b0, w);
      tests++;
      if (w !== 0) begin fails++; $display("FAIL %s_discard_wait got=%0d required=0", tag, w); end
    end
    tests++;
    if (annul !== 1'b0) begin fails++; $display("FAIL %s_annul_end got=%b required=0", tag, annul); end
  endtask

  task automatic test_reset();
    #2;
    tests++;
    if ({out_valid, in_ready, annul, irq_ack, obs} !== '0) begin
      fails++;
      $display("FAIL reset_outputs got=%h required=0", {out_valid, in_ready, annul, irq_ack, obs});
    end
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
    #1;
    tests++;
    if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_release_ready got=%b required=1", in_ready); end
  endtask

  task automatic test_decode();
    int w;
    send(mk(6'b100000, 5'd3, 5'd1, 5'd2), 1'b0, 1'b0, 0, w);
    tests++;
    if ({out_valid, ALUFN, BSEL, WDSEL, WERF, PCSEL} !== {1'b1, 6'b100000, 1'b0, 2'b01, 1'b1, 3'b000}) begin
      fails++;
      $display("FAIL add_direct got=%b required=%b", {out_valid, ALUFN, BSEL, WDSEL, WERF, PCSEL},
               {1'b1, 6'b100000, 1'b0, 2'b01, 1'b1, 3'b000});
    end
    send(mk(6'b110001, 5'd4, 5'd1, 5'd0), 1'b0, 1'b0, 0, w);
    send(mk(6'b011111, 5'd4, 5'd0, 5'd0), 1'b0, 1'b0, 0, w);
    send(mk(6'b101010, 5'd5, 5'd1, 5'd2), 1'b0, 1'b0, 0, w);
  endtask

  task automatic test_load_use();
    int w;
    send(mk(6'b011000, 5'd1, 5'd0, 5'd0), 1'b0, 1'b0, 0, w);
    send(mk(6'b100000, 5'd2, 5'd5, 5'd1), 1'b0, 1'b0, 0, w);
    tests++;
    if (w !== 1) begin fails++; $display("FAIL lu_rb_bubbles got=%0d required=1", w); end
    send(mk(6'b011000, 5'd31, 5'd0, 5'd0), 1'b0, 1'b0, 0, w);
    send(mk(6'b100000, 5'd2, 5'd31, 5'd31), 1'b0, 1'b0, 0, w);
    tests++;
    if (w !== 0) begin fails++; $display("FAIL lu_r31_bubbles got=%0d required=0", w); end
    send(mk(6'b011000, 5'd7, 5'd0, 5'd0), 1'b0, 1'b0, 0, w);
    send(mk(6'b011001, 5'd7, 5'd2, 5'd0), 1'b0, 1'b0, 0, w);
    tests++;
    if (w !== 1) begin fails++; $display("FAIL lu_st_rc_bubbles got=%0d required=1", w); end
  endtask

  task automatic test_branch();
    int w;
    send(mk(6'b011100, 5'd6, 5'd0, 5'd0), 1'b1, 1'b0, 0, w);
    tests++;
    if (annul !== 1'b1) begin fails++; $display("FAIL beq_annul got=%b required=1", annul); end
    discard2("beq");
    send(mk(6'b100001, 5'd3, 5'd1, 5'd2), 1'b0, 1'b0, 0, w);
    send(mk(6'b011101, 5'd6, 5'd0, 5'd0), 1'b1, 1'b0, 0, w);
    tests++;
    if (annul !== 1'b0) begin fails++; $display("FAIL bne_untaken_annul got=%b required=0", annul); end
    send(mk(6'b011101, 5'd6, 5'd0, 5'd0), 1'b0, 1'b0, 0, w);
    present(mk(6'b100000, 5'd9, 5'd9, 5'd9), 1'b0, 1'b0, w);
    repeat (3) @(posedge clk);
    #1;
    tests++;
    if (annul !== 1'b1) begin fails++; $display("FAIL annul_idle_hold got=%b required=1", annul); end
    present(mk(6'b100000, 5'd9, 5'd9, 5'd9), 1'b0, 1'b0, w);
    tests++;
    if (annul !== 1'b0) begin fails++; $display("FAIL bne_annul_end got=%b required=0", annul); end
  endtask

  task automatic test_irq();
    int w;
    @(posedge clk); #1; irq = 4'b0110;
    @(posedge clk); #1; irq = 4'b0000;
    send(mk(6'b100000, 5'd3, 5'd1, 5'd2), 1'b0, 1'b0, 1, w);
    tests++;
    if (irq_ack !== 4'b0010) begin fails++; $display("FAIL irq_ack_first got=%b required=0010", irq_ack); end
    @(posedge clk); #1;
    tests++;
    if (irq_ack !== 4'b0000) begin fails++; $display("FAIL irq_ack_pulse got=%b required=0000", irq_ack); end
    discard2("irq1");
    send(mk(6'b100000, 5'd3, 5'd1, 5'd2), 1'b0, 1'b0, 1, w);
    tests++;
    if (irq_ack !== 4'b0100) begin fails++; $display("FAIL irq_ack_second got=%b required=0100", irq_ack); end
    discard2("irq2");
    @(posedge clk); #1; irq = 4'b0001;
    @(posedge clk); #1; irq = 4'b0000;
    send(mk(6'b100010, 5'd3, 5'd1, 5'd2), 1'b0, 1'b1, 0, w);
    tests++;
    if ({irq_ack, annul} !== 5'b0) begin fails++; $display("FAIL irq_super_mask got=%b required=00000", {irq_ack, annul}); end
    send(mk(6'b100010, 5'd3, 5'd1, 5'd2), 1'b0, 1'b0, 1, w);
    tests++;
    if (irq_ack !== 4'b0001) begin fails++; $display("FAIL irq_ack_third got=%b required=0001", irq_ack); end
    discard2("irq3");
  endtask

  task automatic test_back_to_back();
    int w;
    logic [17:0] st_w;
    st_w = model(6'b011001, 1'b0, 0);
    out_ready = 1'b0;
    send(mk(6'b011001, 5'd3, 5'd2, 5'd0), 1'b0, 1'b0, 0, w);
    instruction = mk(6'b100000, 5'd4, 5'd1, 5'd2); in_valid = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      tests++;
      if ({in_ready, out_valid, MWR, obs} !== {1'b0, 1'b1, 1'b1, st_w}) begin
        fails++;
        $display("FAIL st_hold cycle=%0d got=%h required=%h", c, {in_ready, out_valid, MWR, obs},
                 {1'b0, 1'b1, 1'b1, st_w});
      end
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    send(mk(6'b100000, 5'd4, 5'd1, 5'd2), 1'b0, 1'b0, 0, w);
    for (int k = 0; k < 4; k++) begin
      send(mk(6'b100000 | 6'(k), 5'd10, 5'd11, 5'd12), 1'b0, 1'b0, 0, w);
      tests++;
      if (w !== 0) begin fails++; $display("FAIL b2b_wait k=%0d got=%0d required=0", k, w); end
    end
  endtask

  task automatic test_illop_reset();
    int w;
    send(mk(6'b000000, 5'd0, 5'd0, 5'd0), 1'b0, 1'b0, 0, w);
    out_ready = 1'b0;
    tests++;
    if ({annul, PCSEL, WASEL} !== {1'b1, 3'b011, 1'b1}) begin
      fails++;
      $display("FAIL illop_direct got=%b required=10111", {annul, PCSEL, WASEL});
    end
    present(mk(6'b100000, 5'd9, 5'd9, 5'd9), 1'b0, 1'b0, w);
    tests++;
    if ({annul, out_valid} !== 2'b11) begin fails++; $display("FAIL mid_annul got=%b required=11", {annul, out_valid}); end
    #3 reset = 1'b1;
    #1;
    tests++;
    if ({out_valid, in_ready, annul, irq_ack, obs} !== '0) begin
      fails++;
      $display("FAIL async_reset got=%h required=0", {out_valid, in_ready, annul, irq_ack, obs});
    end
    sb.delete();
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0; out_ready = 1'b1;
    send(mk(6'b100000, 5'd3, 5'd1, 5'd2), 1'b0, 1'b0, 0, w);
    tests++;
    if ({w[0], annul, out_valid} !== 3'b001) begin
      fails++;
      $display("FAIL post_reset_run got=%b required=001", {w[0], annul, out_valid});
    end
  endtask

  initial begin
    test_reset();
    test_decode();
    test_load_use();
    test_branch();
    test_irq();
    test_back_to_back();
    test_illop_reset();
    repeat (3) @(posedge clk);
    #1;
    tests++;
    if (sb.size() != 0) begin fails++; $display("FAIL sb_drain got=%0d required=0", sb.size()); end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
